// File: rtl/reg_write_pkg.sv
// Shared types and helpers for the register-file write queue.
//   WQ_WIDTH / WQ_SELECTOR : default data / register-address widths
//   wq_entry_t             : one queued write {addr, data}
//   ZERO_REG               : hard-wired zero register; writes to it are dropped
//   ptr_inc()              : wrapping pointer increment
package reg_write_pkg;

  localparam int unsigned WQ_WIDTH    = 32;
  localparam int unsigned WQ_SELECTOR = 5;

  typedef struct packed {
    logic [WQ_SELECTOR-1:0] addr;
    logic [WQ_WIDTH-1:0]    data;
  } wq_entry_t;

  localparam logic [WQ_SELECTOR-1:0] ZERO_REG = '0;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 1 == depth) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/wq_fwd_match.sv
// Forwarding matcher for one register-file read port.
// Searches the stored queue entries for the youngest pending write to i_addr.
//   i_entries : queue storage, indexed by raw slot
//   i_valid   : per-slot occupancy mask (derived from head and count)
//   i_head    : oldest slot
//   i_addr    : lookup register address
//   o_hit     : a pending write to i_addr exists (never for the zero register)
//   o_data    : data of the youngest matching entry, 0 on a miss
module wq_fwd_match
  import reg_write_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  wq_entry_t                    i_entries [DEPTH],
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [$clog2(DEPTH)-1:0]     i_head,
  input  logic [WQ_SELECTOR-1:0]       i_addr,
  output logic                         o_hit,
  output logic [WQ_WIDTH-1:0]          o_data
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] w_idx;

  // Walk from the head toward the tail; a later match overrides an earlier one, so the
  // result is the entry closest to the tail (same as a priority search from tail-1 down).
  always_comb begin
    o_hit  = 1'b0;
    o_data = '0;
    w_idx  = i_head;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PtrW'(k);
      if (i_valid[w_idx] && (i_entries[w_idx].addr == i_addr) && (i_addr != ZERO_REG)) begin
        o_hit  = 1'b1;
        o_data = i_entries[w_idx].data;
      end
    end
  end

endmodule

// File: rtl/reg_write_queue.sv
// Register-file write queue: buffers write requests and drains one per cycle into the
// register file's single, handshake-free write port while drain_en_i allows it.
// Optional forwarding of pending writes to two read ports is built only when the macro
// REG_WRITE_QUEUE_FWD_EN is defined; otherwise fwd_hit_*_o / fwd_data_*_o are tied to 0.
//   clk, rst                  : clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o     : producer handshake, wr_addr_i / wr_data_i payload
//   drain_en_i                : register-file write port available this cycle
//   Reg_Write_o, Write_Register_o, Write_Data_o : register-file write port
//   fwd_addr_*_i, fwd_hit_*_o, fwd_data_*_o     : forwarding lookups
//   count_o, empty_o, full_o  : occupancy
module reg_write_queue
  import reg_write_pkg::*;
#(
  parameter int unsigned WIDTH    = WQ_WIDTH,
  parameter int unsigned SELECTOR = WQ_SELECTOR,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [SELECTOR-1:0]        wr_addr_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       drain_en_i,
  output logic                       Reg_Write_o,
  output logic [SELECTOR-1:0]        Write_Register_o,
  output logic [WIDTH-1:0]           Write_Data_o,
  input  logic [SELECTOR-1:0]        fwd_addr_1_i,
  input  logic [SELECTOR-1:0]        fwd_addr_2_i,
  output logic                       fwd_hit_1_o,
  output logic                       fwd_hit_2_o,
  output logic [WIDTH-1:0]           fwd_data_1_o,
  output logic [WIDTH-1:0]           fwd_data_2_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Entry storage uses the package struct, so the widths must agree with it.
  if (WIDTH != WQ_WIDTH || SELECTOR != WQ_SELECTOR || DEPTH < 2 || (1 << PtrW) != DEPTH)
  begin : g_cfg_check
    $error("reg_write_queue: unsupported WIDTH/SELECTOR/DEPTH combination");
  end

  wq_entry_t       r_mem [DEPTH];
  logic [PtrW-1:0] r_head, r_tail;
  logic [CntW-1:0] r_count, w_count_d;
  logic            w_full, w_empty, w_store, w_drain;
  logic [DEPTH-1:0] w_valid;
  logic [PtrW-1:0]  w_off [DEPTH];

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);

  assign full_o     = w_full && !rst;
  assign empty_o    = w_empty || rst;
  assign count_o    = rst ? '0 : r_count;
  assign wr_ready_o = !w_full && !rst;

  // Zero-register writes complete the handshake but are never stored.
  assign w_store = wr_valid_i && wr_ready_o && (wr_addr_i != ZERO_REG);
  assign w_drain = !empty_o && drain_en_i;

  assign Reg_Write_o      = w_drain;
  assign Write_Register_o = empty_o ? '0 : r_mem[r_head].addr;
  assign Write_Data_o     = empty_o ? '0 : r_mem[r_head].data;

  assign w_count_d = r_count + CntW'(w_store) - CntW'(w_drain);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) r_tail <= PtrW'(ptr_inc(32'(r_tail), DEPTH));
      if (w_drain) r_head <= PtrW'(ptr_inc(32'(r_head), DEPTH));
      r_count <= w_count_d;
    end
  end

  // Contents are deliberately not reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_tail] <= {wr_addr_i, wr_data_i};
  end

  // A slot is occupied when its distance from the head (mod DEPTH) is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_valid
    assign w_off[g]   = PtrW'(g) - r_head;
    assign w_valid[g] = ({1'b0, w_off[g]} < r_count);
  end

`ifdef REG_WRITE_QUEUE_FWD_EN
  logic             w_hit_1, w_hit_2;
  logic [WIDTH-1:0] w_data_1, w_data_2;

  wq_fwd_match #(.DEPTH(DEPTH)) u_fwd_match_1 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_addr    (fwd_addr_1_i),
    .o_hit     (w_hit_1),
    .o_data    (w_data_1)
  );

  wq_fwd_match #(.DEPTH(DEPTH)) u_fwd_match_2 (
    .i_entries (r_mem),
    .i_valid   (w_valid),
    .i_head    (r_head),
    .i_addr    (fwd_addr_2_i),
    .o_hit     (w_hit_2),
    .o_data    (w_data_2)
  );

  assign fwd_hit_1_o  = w_hit_1 && !rst;
  assign fwd_hit_2_o  = w_hit_2 && !rst;
  assign fwd_data_1_o = rst ? '0 : w_data_1;
  assign fwd_data_2_o = rst ? '0 : w_data_2;
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{fwd_addr_1_i, fwd_addr_2_i, w_valid};

  assign fwd_hit_1_o  = 1'b0;
  assign fwd_hit_2_o  = 1'b0;
  assign fwd_data_1_o = '0;
  assign fwd_data_2_o = '0;
`endif

endmodule

// File: doc/reg_write_queue.md
Name: reg_write_queue

Overview:
- Buffers register-file write requests from the execute/load stages.
- Drains one request per cycle into the register file's single write port (Reg_Write / Write_Register / Write_Data).
- Absorbs bursts while the write port is blocked by drain_en_i.
- Sits directly upstream of the register file; the downstream write port has no handshake.

Parameters:
WIDTH, 32, data width of a register.
SELECTOR, 5, register address width.
DEPTH, 4, queue entries; power of two, >= 2.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
wr_valid_i  input  1  producer has a write request
wr_ready_o  output  1  queue accepts request this cycle
wr_addr_i  input  SELECTOR  destination register
wr_data_i  input  WIDTH  write data
drain_en_i  input  1  register-file write port available this cycle
Reg_Write_o  output  1  write strobe to register file
Write_Register_o  output  SELECTOR  write address to register file
Write_Data_o  output  WIDTH  write data to register file
fwd_addr_1_i  input  SELECTOR  lookup address, read port 1
fwd_addr_2_i  input  SELECTOR  lookup address, read port 2
fwd_hit_1_o  output  1  pending write to fwd_addr_1_i exists
fwd_hit_2_o  output  1  pending write to fwd_addr_2_i exists
fwd_data_1_o  output  WIDTH  youngest pending data for fwd_addr_1_i
fwd_data_2_o  output  WIDTH  youngest pending data for fwd_addr_2_i
count_o  output  $clog2(DEPTH)+1  occupied entries
empty_o  output  1  count_o == 0
full_o  output  1  count_o == DEPTH

Behaviour:
- Storage: circular buffer of {addr, data}, head/tail pointers mod DEPTH, count register 0..DEPTH.
- Reset (rst=1 at edge): head=tail=count=0.
- Outputs while rst=1: wr_ready_o=0; Reg_Write_o, fwd_hit_*_o, count_o=0; empty_o=1; full_o=0.
- Entry contents are not cleared on reset.
- Reset mid-burst discards all pending entries; no write reaches the register file.
- wr_ready_o = !full_o && !rst. It does not depend on same-cycle drain.
- Enqueue when wr_valid_i && wr_ready_o: entry written at tail, tail++, count++.
- Writes to address 0 are accepted (handshake completes) but not stored; count is unchanged.
- Drain: Reg_Write_o = !empty_o && drain_en_i, combinational.
- Write_Register_o and Write_Data_o always show the head entry; they are 0 when empty.
- When Reg_Write_o=1 the register file captures the write at the edge, then head++ and count--.
- Minimum latency: request accepted at edge N appears as Reg_Write_o=1 in cycle N+1, given drain_en_i=1.
- Simultaneous enqueue and drain (not full): count unchanged, both pointers advance.
- Full with drain: wr_ready_o stays 0 that cycle; the freed slot is usable next cycle.
- Ordering: strictly FIFO; register-file writes occur in acceptance order.
- Forwarding is combinational over stored entries only, including the head being drained this cycle.
- Same-cycle incoming wr_*_i is not searched.
- Hit when any valid entry's addr equals the lookup addr and the lookup addr != 0.
- Data comes from the youngest matching entry, closest to the tail.
- On a miss, fwd_data_*_o = 0.
- Pointer wrap: DEPTH-1 -> 0; the valid-entry mask is computed from head and count, not raw indices.

Optional Feature:
- Macro: REG_WRITE_QUEUE_FWD_EN.
- Defined: forwarding logic is built as described above.
- Undefined: the matcher is not instantiated. fwd_hit_*_o and fwd_data_*_o are tied to 0 and the fwd_addr_*_i ports remain but are unused.
- Queue behaviour is identical in both builds.

Decomposition:
- Package reg_write_pkg contains:
  - typedef wq_entry_t {logic [SELECTOR-1:0] addr; logic [WIDTH-1:0] data;}
  - constant ZERO_REG = '0
  - function ptr_inc (wrapping increment)
- Sub-module wq_fwd_match, instantiated once per read port:
  - inputs: entry array, valid mask, head pointer, lookup address
  - outputs: hit and youngest data (priority search from tail-1 toward head)

Test Plan:
- Reset, then 3 enqueues (r1=0x11, r2=0x22, r3=0x33) with drain_en_i=0 -> count_o=3, Reg_Write_o=0. Raise drain_en_i -> writes r1, r2, r3 on 3 consecutive cycles, then empty_o=1.
- Fill with DEPTH=4 writes, drain_en_i=0 -> full_o=1, wr_ready_o=0. A 5th request is held. One drain cycle -> wr_ready_o=1 next cycle, 5th accepted, order preserved.
- Enqueue r5=0xA then r5=0xB, fwd_addr_1_i=5 -> fwd_hit_1_o=1, fwd_data_1_o=0xB. After both drain -> fwd_hit_1_o=0.
- Enqueue r0=0xDEAD -> handshake completes, count_o unchanged, fwd_addr_2_i=0 gives fwd_hit_2_o=0, no Reg_Write_o.
- Continuous enqueue + drain for 10 cycles across pointer wrap -> count_o constant at 1, data sequence intact.
- Assert rst with count_o=3 -> next cycle count_o=0, empty_o=1, Reg_Write_o=0, no pending write emitted.
